// File: rtl/seg7_banner_monitor_pkg.sv
// Shared constants for the 7-segment banner monitor: segment patterns,
// decoded codes, FSM encoding and small anode helpers.
package seg7_banner_monitor_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    // Capture FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETTLE = 2'b01;
    localparam logic [1:0] ST_HELD   = 2'b10;

    // True when exactly one (active-low) anode is driven
    function automatic logic f_one_low(input logic [3:0] an);
        return (an == 4'b0111) || (an == 4'b1011) ||
               (an == 4'b1101) || (an == 4'b1110);
    endfunction

    // Slot index of the single low anode; only meaningful for legal samples
    function automatic logic [1:0] f_slot_idx(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_banner_monitor_decoder.sv
// Combinational segment-pattern to 4-bit code decoder. Digits 0-9 map to
// their value, all-off maps to blank, anything else is flagged bad.
module seg7_pattern_decoder
    import seg7_banner_monitor_pkg::*;
(
    input  logic [6:0] i_segment,
    output logic [3:0] o_code
);

    // Pattern lookup; unknown patterns fall through to the bad code
    always_comb begin
        o_code = CODE_BAD;
        case (i_segment)
            SEG_0:     o_code = 4'h0;
            SEG_1:     o_code = 4'h1;
            SEG_2:     o_code = 4'h2;
            SEG_3:     o_code = 4'h3;
            SEG_4:     o_code = 4'h4;
            SEG_5:     o_code = 4'h5;
            SEG_6:     o_code = 4'h6;
            SEG_7:     o_code = 4'h7;
            SEG_8:     o_code = 4'h8;
            SEG_9:     o_code = 4'h9;
            SEG_BLANK: o_code = CODE_BLANK;
            default:   o_code = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_banner_monitor.sv
// Reader for the multiplexed 7-segment banner bus. Double-registers the
// pins, waits for each digit to hold steady, decodes it into its slot and,
// once all four slots are seen, publishes the frame and classifies how it
// moved relative to the previous frame.
module seg7_banner_monitor
    import seg7_banner_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [3:0]  i_anode,
    input  logic [6:0]  i_segment,
    output logic [15:0] o_frame,
    output logic        o_frame_valid,
    output logic        o_shift_l,
    output logic        o_shift_r,
    output logic        o_same,
    output logic        o_bad_pattern,
    output logic        o_stalled
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]       r_an_s1, r_an_s2;
    logic [6:0]       r_seg_s1, r_seg_s2;
    logic [1:0]       r_state;
    logic [SCW-1:0]   r_stab_cnt;
    logic [3:0]       r_lat_an;
    logic [6:0]       r_lat_seg;
    logic [3:0][3:0]  r_slots;
    logic [3:0]       r_seen;
    logic [TOW-1:0]   r_to_cnt;
    logic [15:0]      r_prev;
    logic             r_prev_valid;

    logic [3:0]       w_code;
    logic             w_legal;
    logic             w_match;
    logic [1:0]       w_idx;
    logic             w_capture;
    logic             w_timeout;
    logic [3:0][3:0]  w_slots_nxt;
    logic [3:0]       w_seen_nxt;
    logic             w_complete;
    logic [15:0]      w_new;
    logic             w_eq, w_shl, w_shr, w_bad;

    seg7_pattern_decoder u_dec (
        .i_segment (r_seg_s2),
        .o_code    (w_code)
    );

    // Two-stage input synchroniser; keeps sampling even while disabled
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_an_s1  <= 4'h0;
            r_an_s2  <= 4'h0;
            r_seg_s1 <= 7'h0;
            r_seg_s2 <= 7'h0;
        end else begin
            r_an_s1  <= i_anode;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= i_segment;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // Capture qualification, slot merge and frame classification
    always_comb begin
        w_legal   = f_one_low(r_an_s2);
        w_match   = (r_an_s2 == r_lat_an) && (r_seg_s2 == r_lat_seg);
        w_idx     = f_slot_idx(r_lat_an);
        w_timeout = i_en && (r_seen != 4'h0) &&
                    (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
        // Timeout wins over a coincident capture: the partial frame is dropped
        w_capture = i_en && !w_timeout && (r_state == ST_SETTLE) && w_match &&
                    (r_stab_cnt == SCW'(STABLE_CYCLES - 1));

        w_slots_nxt = r_slots;
        w_seen_nxt  = r_seen;
        if (w_capture) begin
            w_slots_nxt[w_idx] = w_code;
            w_seen_nxt[w_idx]  = 1'b1;
        end
        w_complete = w_capture && (w_seen_nxt == 4'hF);
        w_new      = w_slots_nxt;

        w_eq  = r_prev_valid && (w_new == r_prev);
        w_shl = r_prev_valid && !w_eq && (w_new[15:4] == r_prev[11:0]);
        w_shr = r_prev_valid && !w_eq && !w_shl && (w_new[11:0] == r_prev[15:4]);
        w_bad = (w_new[15:12] == CODE_BAD) || (w_new[11:8] == CODE_BAD) ||
                (w_new[7:4]   == CODE_BAD) || (w_new[3:0]  == CODE_BAD);
    end

    // Settle FSM: one capture per anode activation, restart on any change
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_stab_cnt <= '0;
            r_lat_an   <= 4'h0;
            r_lat_seg  <= 7'h0;
        end else if (i_en) begin
            if (w_timeout) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_legal) begin
                            r_stab_cnt <= SCW'(1);
                            r_lat_an   <= r_an_s2;
                            r_lat_seg  <= r_seg_s2;
                            r_state    <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_match) begin
                            if (w_capture) r_state <= ST_HELD;
                            else           r_stab_cnt <= r_stab_cnt + SCW'(1);
                        end else if (w_legal) begin
                            r_stab_cnt <= SCW'(1);
                            r_lat_an   <= r_an_s2;
                            r_lat_seg  <= r_seg_s2;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (!w_match) begin
                            if (w_legal) begin
                                r_stab_cnt <= SCW'(1);
                                r_lat_an   <= r_an_s2;
                                r_lat_seg  <= r_seg_s2;
                                r_state    <= ST_SETTLE;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Slot store, seen mask, timeout watchdog and frame publication
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_slots       <= '0;
            r_seen        <= 4'h0;
            r_to_cnt      <= '0;
            r_prev        <= 16'h0;
            r_prev_valid  <= 1'b0;
            o_frame       <= 16'h0;
            o_frame_valid <= 1'b0;
            o_shift_l     <= 1'b0;
            o_shift_r     <= 1'b0;
            o_same        <= 1'b0;
            o_bad_pattern <= 1'b0;
            o_stalled     <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            o_shift_l     <= 1'b0;
            o_shift_r     <= 1'b0;
            o_same        <= 1'b0;
            o_bad_pattern <= 1'b0;
            if (i_en) begin
                if (w_timeout) begin
                    r_seen    <= 4'h0;
                    r_to_cnt  <= '0;
                    o_stalled <= 1'b1;
                end else begin
                    r_slots <= w_slots_nxt;
                    if (w_complete) begin
                        r_seen        <= 4'h0;
                        r_to_cnt      <= '0;
                        o_frame       <= w_new;
                        o_frame_valid <= 1'b1;
                        o_same        <= w_eq;
                        o_shift_l     <= w_shl;
                        o_shift_r     <= w_shr;
                        o_bad_pattern <= w_bad;
                        o_stalled     <= 1'b0;
                        r_prev        <= w_new;
                        r_prev_valid  <= 1'b1;
                    end else begin
                        r_seen   <= w_seen_nxt;
                        r_to_cnt <= (r_seen != 4'h0) ? r_to_cnt + TOW'(1) : '0;
                    end
                end
            end
        end
    end

endmodule
